short_stack: RTL and testbench

- Responder for the trav_to_ss request channel; holds one circular short stack per in-flight ray, plus a per-ray restart (rest) node.
- Accepts push, pop and update-restnode requests from the traversal unit.
- A pop re-issues the popped far child, or a kd-restart from the rest node, to the traversal arbiter (tarb).
- A ray whose restart interval is exhausted is reported on the miss port.

---
 rtl/short_stack_if.sv | 60 ++++++
 rtl/short_stack.sv | 151 +++++++++++++++
 tb/tb_short_stack.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/short_stack_if.sv
// Request, re-issue and miss channels between the traversal unit and the
// short stack. The stack itself connects through the slave modport.
interface short_stack_if #(
   parameter int RAY_W  = 9,
   parameter int NODE_W = 16
);
   // Ray initialisation
   logic              clr_valid;
   logic [RAY_W-1:0]  clr_rayID;
   logic [31:0]       clr_t_max;

   // trav_to_ss request channel
   logic              req_valid;
   logic [RAY_W-1:0]  req_rayID;
   logic              req_push;
   logic [NODE_W-1:0] req_push_node;
   logic              req_upd_rest;
   logic [NODE_W-1:0] req_rest_node;
   logic [31:0]       req_t_max;
   logic              req_pop;
   logic              req_stall;

   // Re-issue to the traversal arbiter
   logic              tarb_valid;
   logic [RAY_W-1:0]  tarb_rayID;
   logic [NODE_W-1:0] tarb_nodeID;
   logic              tarb_restnode_search;
   logic [31:0]       tarb_t_min;
   logic [31:0]       tarb_t_max;
   logic              tarb_stall;

   // Finished rays
   logic              miss_valid;
   logic [RAY_W-1:0]  miss_rayID;
   logic              miss_stall;

   modport master (
      output clr_valid, clr_rayID, clr_t_max,
      output req_valid, req_rayID, req_push, req_push_node,
      output req_upd_rest, req_rest_node, req_t_max, req_pop,
      input  req_stall,
      input  tarb_valid, tarb_rayID, tarb_nodeID, tarb_restnode_search,
      input  tarb_t_min, tarb_t_max,
      output tarb_stall,
      input  miss_valid, miss_rayID,
      output miss_stall
   );

   modport slave (
      input  clr_valid, clr_rayID, clr_t_max,
      input  req_valid, req_rayID, req_push, req_push_node,
      input  req_upd_rest, req_rest_node, req_t_max, req_pop,
      output req_stall,
      output tarb_valid, tarb_rayID, tarb_nodeID, tarb_restnode_search,
      output tarb_t_min, tarb_t_max,
      input  tarb_stall,
      output miss_valid, miss_rayID,
      input  miss_stall
   );
endinterface

// File: rtl/short_stack.sv
// Per-ray circular short stack with a kd-restart rest node. Pops re-issue the
// far child (or a restart from the rest node) to tarb, or report a miss once
// the ray's restart interval is used up.
module short_stack #(
   parameter int RAY_W  = 9,
   parameter int DEPTH  = 4,
   parameter int NODE_W = 16
) (
   input logic          clk,
   input logic          rst,
   short_stack_if.slave bus
);
   localparam int RAYS  = 2 ** RAY_W;
   localparam int TOP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [NODE_W-1:0] node;
      logic [31:0]       t_max;
   } entry_t;

   // Per-ray state: metadata plus the stack entries themselves
   logic [TOP_W-1:0]  top_q       [RAYS];
   logic [CNT_W-1:0]  cnt_q       [RAYS];
   logic [NODE_W-1:0] rest_node_q [RAYS];
   logic [31:0]       rest_t_q    [RAYS];
   entry_t            ent_q       [RAYS][DEPTH];

   logic              accept;
   logic              do_push;
   logic              do_upd;
   logic              pop_hit;
   logic              pop_restart;
   logic              pop_miss;
   logic [TOP_W-1:0]  cur_top;
   logic [TOP_W-1:0]  push_top;
   logic [TOP_W-1:0]  pop_top;
   logic [CNT_W-1:0]  cur_cnt;
   logic [CNT_W-1:0]  push_cnt;
   logic [NODE_W-1:0] cur_rest_node;
   logic [31:0]       cur_rest_t;
   entry_t            top_ent;
   logic              stack_empty;
   logic              interval_left;

   // A clear or a blocked output holds off new requests; nothing stalls in reset
   assign bus.req_stall = rst & (bus.clr_valid
                                 | (bus.tarb_valid & bus.tarb_stall)
                                 | (bus.miss_valid & bus.miss_stall));

   // Combinational read of the requesting ray's state and request decode
   // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
   always_comb begin
      cur_top       = top_q[bus.req_rayID];
      cur_cnt       = cnt_q[bus.req_rayID];
      cur_rest_node = rest_node_q[bus.req_rayID];
      cur_rest_t    = rest_t_q[bus.req_rayID];
      top_ent       = ent_q[bus.req_rayID][cur_top];

      accept        = bus.req_valid & ~bus.req_stall;
      do_push       = accept & bus.req_push;
      do_upd        = accept & bus.req_upd_rest;
      stack_empty   = (cur_cnt == '0);
      // Non-negative floats order the same way as their unsigned bit patterns
      interval_left = (bus.req_t_max < cur_rest_t);
      pop_hit       = accept & bus.req_pop & ~stack_empty;
      pop_restart   = accept & bus.req_pop & stack_empty & interval_left;
      pop_miss      = accept & bus.req_pop & stack_empty & ~interval_left;

      push_top      = cur_top + TOP_W'(1);
      pop_top       = cur_top - TOP_W'(1);
      push_cnt      = (cur_cnt == FULL) ? FULL : cur_cnt + CNT_W'(1);
   end

   // Per-ray metadata: clear, push, rest-node update and pop bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: only the metadata is reset -- count=0 makes every entry dead, so the entry array needs none.
         for (int i = 0; i < RAYS; i++) begin
            top_q[i]       <= '0;
            cnt_q[i]       <= '0;
            rest_node_q[i] <= '0;
            rest_t_q[i]    <= '0;
         end
      end else if (bus.clr_valid) begin
         // NOTE: non-blocking assignments keep this state update race-free against the readers above.
         top_q[bus.clr_rayID]       <= '0;
         cnt_q[bus.clr_rayID]       <= '0;
         rest_node_q[bus.clr_rayID] <= '0;
         rest_t_q[bus.clr_rayID]    <= bus.clr_t_max;
      end else begin
         if (do_push) begin
            top_q[bus.req_rayID] <= push_top;
            cnt_q[bus.req_rayID] <= push_cnt;
         end else if (pop_hit) begin
            top_q[bus.req_rayID] <= pop_top;
            cnt_q[bus.req_rayID] <= cur_cnt - CNT_W'(1);
         end
         if (do_upd) begin
            rest_node_q[bus.req_rayID] <= bus.req_rest_node;
         end
      end
   end

   // Stack entry storage; a full stack silently overwrites its oldest entry
   always_ff @(posedge clk) begin
      if (do_push) begin
         ent_q[bus.req_rayID][push_top] <= '{node: bus.req_push_node, t_max: bus.req_t_max};
      end
   end

   // Re-issue register toward tarb: load on a hit or restart, hold while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.tarb_valid           <= 1'b0;
         bus.tarb_rayID           <= '0;
         bus.tarb_nodeID          <= '0;
         bus.tarb_restnode_search <= 1'b0;
         bus.tarb_t_min           <= '0;
         bus.tarb_t_max           <= '0;
      end else if (pop_hit | pop_restart) begin
         bus.tarb_valid           <= 1'b1;
         bus.tarb_rayID           <= bus.req_rayID;
         bus.tarb_nodeID          <= pop_hit ? top_ent.node : cur_rest_node;
         bus.tarb_restnode_search <= pop_restart;
         bus.tarb_t_min           <= bus.req_t_max;
         bus.tarb_t_max           <= pop_hit ? top_ent.t_max : cur_rest_t;
      end else if (bus.tarb_valid & ~bus.tarb_stall) begin
         bus.tarb_valid <= 1'b0;
      end
   end

   // Miss register: load when the restart interval is exhausted, hold while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.miss_valid <= 1'b0;
         bus.miss_rayID <= '0;
      end else if (pop_miss) begin
         bus.miss_valid <= 1'b1;
         bus.miss_rayID <= bus.req_rayID;
      end else if (bus.miss_valid & ~bus.miss_stall) begin
         bus.miss_valid <= 1'b0;
      end
   end

   // A pop must not be combined with a push or a rest-node update
   illegal_pop_combo : assert property (@(posedge clk) disable iff (!rst)
      (bus.req_valid & bus.req_pop) |-> !(bus.req_push | bus.req_upd_rest));

endmodule

// File: tb/tb_short_stack.sv
// Directed bench for short_stack: push/pop, wrap-around overwrite, rest-node
// restart and miss, backpressure holding, clear priority and mid-run reset.
module tb_short_stack;
   localparam int RAY_W  = 9;
   localparam int DEPTH  = 4;
   localparam int NODE_W = 16;

   typedef logic [90:0] snap_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   short_stack_if #(.RAY_W(RAY_W), .NODE_W(NODE_W)) bus ();

   short_stack #(.RAY_W(RAY_W), .DEPTH(DEPTH), .NODE_W(NODE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic snap_t tarb_snap();
      return {bus.tarb_valid, bus.tarb_rayID, bus.tarb_nodeID,
              bus.tarb_restnode_search, bus.tarb_t_min, bus.tarb_t_max};
   endfunction

   function automatic snap_t mk(input logic v, input logic [8:0] ray, input logic [15:0] node,
                                input logic rs, input logic [31:0] tmin, input logic [31:0] tmax);
      return {v, ray, node, rs, tmin, tmax};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      bus.req_valid     = 1'b0;
      bus.req_rayID     = '0;
      bus.req_push      = 1'b0;
      bus.req_push_node = '0;
      bus.req_upd_rest  = 1'b0;
      bus.req_rest_node = '0;
      bus.req_t_max     = '0;
      bus.req_pop       = 1'b0;
   endtask

   task automatic do_clear(input logic [8:0] ray, input logic [31:0] tmax);
      bus.clr_valid = 1'b1;
      bus.clr_rayID = ray;
      bus.clr_t_max = tmax;
      step();
      bus.clr_valid = 1'b0;
   endtask

   // Presents one request and returns #1 after the edge that accepted it
   task automatic send_req(input logic [8:0] ray, input logic push, input logic [15:0] pnode,
                           input logic upd, input logic [15:0] rnode, input logic [31:0] tmax,
                           input logic pop);
      logic accepted;
      bus.req_valid     = 1'b1;
      bus.req_rayID     = ray;
      bus.req_push      = push;
      bus.req_push_node = pnode;
      bus.req_upd_rest  = upd;
      bus.req_rest_node = rnode;
      bus.req_t_max     = tmax;
      bus.req_pop       = pop;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
         #1;
         accepted = !bus.req_stall;
         step();
      end
      idle_req();
      if (!accepted) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_accept_timeout ray=%0d got stall=1 want accept", ray);
      end
   endtask

   task automatic test_reset();
      bus.clr_valid = 1'b1;
      #1;
      n_tests++;
      if (bus.req_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_stall got %b want 0", bus.req_stall);
      end
      n_tests++;
      if (tarb_snap() !== snap_t'(0)) begin
         n_fail++;
         $display("FAIL reset_tarb got %h want 0", tarb_snap());
      end
      n_tests++;
      if ({bus.miss_valid, bus.miss_rayID} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_miss got %b/%0d want 0/0", bus.miss_valid, bus.miss_rayID);
      end
      bus.clr_valid = 1'b0;
      rst = 1'b1;
      step();
   endtask

   task automatic test_push_pop();
      do_clear(9'd5, 32'h4120_0000);
      send_req(9'd5, 1'b1, 16'd7, 1'b0, 16'd0, 32'h40A0_0000, 1'b0);
      send_req(9'd5, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4000_0000, 1'b1);
      n_tests++;
      if (tarb_snap() !== mk(1'b1, 9'd5, 16'd7, 1'b0, 32'h4000_0000, 32'h40A0_0000)) begin
         n_fail++;
         $display("FAIL push_pop_hit got %h want %h", tarb_snap(),
                  mk(1'b1, 9'd5, 16'd7, 1'b0, 32'h4000_0000, 32'h40A0_0000));
      end
      step();
      n_tests++;
      if (bus.tarb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL push_pop_valid_clears got %b want 0", bus.tarb_valid);
      end
      // Stack is empty again, so the next pop restarts from the root
      send_req(9'd5, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4000_0000, 1'b1);
      n_tests++;
      if (tarb_snap() !== mk(1'b1, 9'd5, 16'd0, 1'b1, 32'h4000_0000, 32'h4120_0000)) begin
         n_fail++;
         $display("FAIL push_pop_empty_restart got %h want %h", tarb_snap(),
                  mk(1'b1, 9'd5, 16'd0, 1'b1, 32'h4000_0000, 32'h4120_0000));
      end
      step();
   endtask

   task automatic test_wrap();
      logic [15:0] exp_node [5] = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd0};
      logic [31:0] exp_tmax [5] = '{32'h4000_0005, 32'h4000_0004, 32'h4000_0003,
                                    32'h4000_0002, 32'h4120_0000};
      logic        exp_rs   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      snap_t       exp;
      do_clear(9'd3, 32'h4120_0000);
      for (int n = 1; n <= 5; n++) begin
         send_req(9'd3, 1'b1, 16'(n), 1'b0, 16'd0, 32'h4000_0000 + 32'(n), 1'b0);
      end
      for (int k = 0; k < 5; k++) begin
         send_req(9'd3, 1'b0, 16'd0, 1'b0, 16'd0, 32'h3F80_0000, 1'b1);
         exp = mk(1'b1, 9'd3, exp_node[k], exp_rs[k], 32'h3F80_0000, exp_tmax[k]);
         n_tests++;
         if (tarb_snap() !== exp) begin
            n_fail++;
            $display("FAIL wrap_pop%0d got %h want %h", k, tarb_snap(), exp);
         end
      end
      step();
   endtask

   task automatic test_restart();
      do_clear(9'd9, 32'h4120_0000);
      send_req(9'd9, 1'b0, 16'd0, 1'b1, 16'd12, 32'h0, 1'b0);
      send_req(9'd9, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4080_0000, 1'b1);
      n_tests++;
      if (tarb_snap() !== mk(1'b1, 9'd9, 16'd12, 1'b1, 32'h4080_0000, 32'h4120_0000)) begin
         n_fail++;
         $display("FAIL restart_rest_node got %h want %h", tarb_snap(),
                  mk(1'b1, 9'd9, 16'd12, 1'b1, 32'h4080_0000, 32'h4120_0000));
      end
      // req_t_max equal to rest_t_max: interval exhausted
      send_req(9'd9, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4120_0000, 1'b1);
      n_tests++;
      if ({bus.miss_valid, bus.miss_rayID, bus.tarb_valid} !== {1'b1, 9'd9, 1'b0}) begin
         n_fail++;
         $display("FAIL restart_miss got v=%b ray=%0d tarb_v=%b want v=1 ray=9 tarb_v=0",
                  bus.miss_valid, bus.miss_rayID, bus.tarb_valid);
      end
      // Push and rest-node update in one request both take effect
      send_req(9'd9, 1'b1, 16'd20, 1'b1, 16'd30, 32'h4100_0000, 1'b0);
      n_tests++;
      if (bus.miss_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_miss_clears got %b want 0", bus.miss_valid);
      end
      send_req(9'd9, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4000_0000, 1'b1);
      n_tests++;
      if (tarb_snap() !== mk(1'b1, 9'd9, 16'd20, 1'b0, 32'h4000_0000, 32'h4100_0000)) begin
         n_fail++;
         $display("FAIL restart_push_upd_pop got %h want %h", tarb_snap(),
                  mk(1'b1, 9'd9, 16'd20, 1'b0, 32'h4000_0000, 32'h4100_0000));
      end
      send_req(9'd9, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4000_0000, 1'b1);
      n_tests++;
      if (tarb_snap() !== mk(1'b1, 9'd9, 16'd30, 1'b1, 32'h4000_0000, 32'h4120_0000)) begin
         n_fail++;
         $display("FAIL restart_new_rest got %h want %h", tarb_snap(),
                  mk(1'b1, 9'd9, 16'd30, 1'b1, 32'h4000_0000, 32'h4120_0000));
      end
      step();
   endtask

   task automatic test_stall();
      snap_t exp;
      do_clear(9'd2, 32'h4120_0000);
      send_req(9'd2, 1'b1, 16'd40, 1'b0, 16'd0, 32'h4040_0000, 1'b0);
      send_req(9'd2, 1'b1, 16'd41, 1'b0, 16'd0, 32'h4080_0000, 1'b0);
      bus.tarb_stall = 1'b1;
      send_req(9'd2, 1'b0, 16'd0, 1'b0, 16'd0, 32'h3F80_0000, 1'b1);
      exp = mk(1'b1, 9'd2, 16'd41, 1'b0, 32'h3F80_0000, 32'h4080_0000);
      // Queue a second pop while tarb is blocked
      bus.req_valid = 1'b1;
      bus.req_rayID = 9'd2;
      bus.req_t_max = 32'h3F80_0000;
      bus.req_pop   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (bus.req_stall !== 1'b1 || tarb_snap() !== exp) begin
            n_fail++;
            $display("FAIL stall_hold%0d got stall=%b %h want stall=1 %h",
                     i, bus.req_stall, tarb_snap(), exp);
         end
         step();
      end
      bus.tarb_stall = 1'b0;
      step();
      idle_req();
      exp = mk(1'b1, 9'd2, 16'd40, 1'b0, 32'h3F80_0000, 32'h4040_0000);
      n_tests++;
      if (tarb_snap() !== exp) begin
         n_fail++;
         $display("FAIL stall_release_pop got %h want %h", tarb_snap(), exp);
      end
      step();
      n_tests++;
      if (bus.tarb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_valid_clears got %b want 0", bus.tarb_valid);
      end
      // Miss channel backpressure
      do_clear(9'd11, 32'h4000_0000);
      bus.miss_stall = 1'b1;
      send_req(9'd11, 1'b0, 16'd0, 1'b0, 16'd0, 32'h4000_0000, 1'b1);
      step();
      #1;
      n_tests++;
      if ({bus.req_stall, bus.miss_valid, bus.miss_rayID} !== {1'b1, 1'b1, 9'd11}) begin
         n_fail++;
         $display("FAIL miss_stall_hold got stall=%b v=%b ray=%0d want stall=1 v=1 ray=11",
                  bus.req_stall, bus.miss_valid, bus.miss_rayID);
      end
      bus.miss_stall = 1'b0;
      step();
      n_tests++;
      if (bus.miss_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_release got %b want 0", bus.miss_valid);
      end
   endtask

   task automatic test_clear_priority();
      snap_t exp;
      do_clear(9'd6, 32'h4120_0000);
      send_req(9'd6, 1'b1, 16'd50, 1'b0, 16'd0, 32'h4000_0000, 1'b0);
      bus.clr_valid = 1'b1;
      bus.clr_rayID = 9'd6;
      bus.clr_t_max = 32'h4200_0000;
      bus.req_valid = 1'b1;
      bus.req_rayID = 9'd6;
      bus.req_t_max = 32'h3F80_0000;
      bus.req_pop   = 1'b1;
      #1;
      n_tests++;
      if (bus.req_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_stalls_req got %b want 1", bus.req_stall);
      end
      step();
      bus.clr_valid = 1'b0;
      n_tests++;
      if (bus.tarb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_no_issue got %b want 0", bus.tarb_valid);
      end
      step();
      idle_req();
      exp = mk(1'b1, 9'd6, 16'd0, 1'b1, 32'h3F80_0000, 32'h4200_0000);
      n_tests++;
      if (tarb_snap() !== exp) begin
         n_fail++;
         $display("FAIL clear_then_pop got %h want %h", tarb_snap(), exp);
      end
      step();
   endtask

   task automatic test_reset_mid();
      do_clear(9'd4, 32'h4120_0000);
      send_req(9'd4, 1'b1, 16'd60, 1'b0, 16'd0, 32'h4000_0000, 1'b0);
      send_req(9'd4, 1'b1, 16'd61, 1'b0, 16'd0, 32'h4040_0000, 1'b0);
      do_clear(9'd7, 32'h4120_0000);
      send_req(9'd7, 1'b1, 16'd70, 1'b0, 16'd0, 32'h4000_0000, 1'b0);
      bus.tarb_stall = 1'b1;
      send_req(9'd4, 1'b0, 16'd0, 1'b0, 16'd0, 32'h3F80_0000, 1'b1);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({tarb_snap(), bus.miss_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got %h/%b want 0/0", tarb_snap(), bus.miss_valid);
      end
      step();
      bus.tarb_stall = 1'b0;
      rst = 1'b1;
      step();
      send_req(9'd4, 1'b0, 16'd0, 1'b0, 16'd0, 32'h3F80_0000, 1'b1);
      n_tests++;
      if ({bus.miss_valid, bus.miss_rayID, bus.tarb_valid} !== {1'b1, 9'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_ray4 got v=%b ray=%0d tarb_v=%b want v=1 ray=4 tarb_v=0",
                  bus.miss_valid, bus.miss_rayID, bus.tarb_valid);
      end
      send_req(9'd7, 1'b0, 16'd0, 1'b0, 16'd0, 32'h0, 1'b1);
      n_tests++;
      if ({bus.miss_valid, bus.miss_rayID, bus.tarb_valid} !== {1'b1, 9'd7, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_ray7 got v=%b ray=%0d tarb_v=%b want v=1 ray=7 tarb_v=0",
                  bus.miss_valid, bus.miss_rayID, bus.tarb_valid);
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      bus.clr_valid  = 1'b0;
      bus.clr_rayID  = '0;
      bus.clr_t_max  = '0;
      bus.tarb_stall = 1'b0;
      bus.miss_stall = 1'b0;
      idle_req();
      step();
      step();
      test_reset();
      test_push_pop();
      test_wrap();
      test_restart();
      test_stall();
      test_clear_priority();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
